// File: rtl/axi4s_pkg.sv
// Shared AXI4-Stream typedefs used by the stream width converters and FIFOs.
package axi4s_pkg;

    // Holding register empty (IDLE) or carrying a beat still being sliced (SEND).
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle: S is the receiving side, M the driving side.
interface axi4_stream_if #(
    parameter int AXI4SDATALEN = 32
);
    logic                    TVALID;
    logic                    TREADY;
    logic                    TLAST;
    logic [AXI4SDATALEN-1:0] TDATA;

    modport S (input TVALID, input TDATA, input TLAST, output TREADY);
    modport M (output TVALID, output TDATA, output TLAST, input TREADY);
endinterface

// File: rtl/axi4s_downsizer.sv
// Splits each wide AXI4-Stream beat into RATIO narrow beats, with no bubble
// between consecutive wide beats when the input keeps up.
module axi4s_downsizer
    import axi4s_pkg::*;
#(
    parameter int WR_DLEN   = 32,
    parameter int RD_DLEN   = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic      aclk,
    input  logic      aresetn,
    axi4_stream_if.S  wr,
    axi4_stream_if.M  rd,
    output state_t    state_dbg
);
    localparam int RATIO = WR_DLEN / RD_DLEN;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    if (((WR_DLEN % RD_DLEN) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $error("axi4s_downsizer: WR_DLEN must be an integer multiple (>=2) of RD_DLEN");
    end

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WR_DLEN-1:0]  hold;
    logic                hold_last;
    logic [CW-1:0]       idx;
    logic                last_slice;
    logic                wr_hs;
    logic                rd_hs;

    // Handshake: a transfer happens on a rising edge where TVALID and TREADY are
    // both high; once TVALID is up, TDATA/TLAST hold until that transfer.
    assign last_slice = (cnt == CNT_MAX);
    assign idx        = (LSB_FIRST != 0) ? cnt : (CNT_MAX - cnt);
    assign wr_hs      = wr.TVALID && wr.TREADY;
    assign rd_hs      = rd.TVALID && rd.TREADY;

    // Ready is combinational on rd.TREADY so a new beat can replace the last slice.
    assign wr.TREADY = aresetn && ((state == IDLE) || (last_slice && rd.TREADY));
    assign rd.TVALID = (state == SEND);
    assign rd.TDATA  = (state == SEND) ? hold[idx*RD_DLEN +: RD_DLEN] : '0;
    assign rd.TLAST  = (state == SEND) && hold_last && last_slice;
    assign state_dbg = state;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            hold_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_hs) begin
                        hold      <= wr.TDATA;
                        hold_last <= wr.TLAST;
                        cnt       <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (rd_hs) begin
                        if (!last_slice) begin
                            cnt <= cnt + 1'b1;
                        end else if (wr_hs) begin
                            hold      <= wr.TDATA;
                            hold_last <= wr.TLAST;
                            cnt       <= '0;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4s_downsizer.sv
// Bench for axi4s_downsizer: directed scenarios plus a randomized stress run,
// with a scoreboard per instance (LSB-first and MSB-first).
module tb_axi4s_downsizer;
    import axi4s_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t st1;
    state_t st2;

    int total = 0;
    int bad   = 0;
    int in_last_cnt  = 0;
    int out_last_cnt = 0;
    logic w1_fire = 1'b0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_q2[$];

    axi4_stream_if #(.AXI4SDATALEN(32)) w1();
    axi4_stream_if #(.AXI4SDATALEN(8))  r1();
    axi4_stream_if #(.AXI4SDATALEN(32)) w2();
    axi4_stream_if #(.AXI4SDATALEN(8))  r2();

    axi4s_downsizer #(.WR_DLEN(32), .RD_DLEN(8), .LSB_FIRST(1)) dut_lsb (
        .aclk(clk), .aresetn(rst_n), .wr(w1), .rd(r1), .state_dbg(st1)
    );

    axi4s_downsizer #(.WR_DLEN(32), .RD_DLEN(8), .LSB_FIRST(0)) dut_msb (
        .aclk(clk), .aresetn(rst_n), .wr(w2), .rd(r2), .state_dbg(st2)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        w1_fire = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (r1.TVALID && r1.TREADY) begin
                if (r1.TLAST) out_last_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_lsb: got %h, expected no output", {r1.TLAST, r1.TDATA});
                end else begin
                    e = exp_q.pop_front();
                    if ({r1.TLAST, r1.TDATA} !== e) begin
                        bad++;
                        $display("FAIL sb_lsb: got last/data %h, want %h", {r1.TLAST, r1.TDATA}, e);
                    end
                end
            end
            if (w1.TVALID && w1.TREADY) begin
                w1_fire = 1'b1;
                if (w1.TLAST) in_last_cnt++;
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({w1.TLAST && (k == 3), w1.TDATA[k*8 +: 8]});
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            exp_q2.delete();
        end else begin
            if (r2.TVALID && r2.TREADY) begin
                total++;
                if (exp_q2.size() == 0) begin
                    bad++;
                    $display("FAIL sb_msb: got %h, expected no output", {r2.TLAST, r2.TDATA});
                end else begin
                    e = exp_q2.pop_front();
                    if ({r2.TLAST, r2.TDATA} !== e) begin
                        bad++;
                        $display("FAIL sb_msb: got last/data %h, want %h", {r2.TLAST, r2.TDATA}, e);
                    end
                end
            end
            if (w2.TVALID && w2.TREADY) begin
                for (int k = 0; k < 4; k++)
                    exp_q2.push_back({w2.TLAST && (k == 3), w2.TDATA[(3-k)*8 +: 8]});
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        w1.TVALID = 1'b0; w1.TDATA = '0; w1.TLAST = 1'b0; r1.TREADY = 1'b1;
        w2.TVALID = 1'b0; w2.TDATA = '0; w2.TLAST = 1'b0; r2.TREADY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b0 || r1.TDATA !== 8'h00 || r1.TLAST !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd: got valid=%b data=%h last=%b, want 0 00 0", r1.TVALID, r1.TDATA, r1.TLAST);
        end
        total++;
        if (w1.TREADY !== 1'b0) begin
            bad++;
            $display("FAIL reset_wr_ready: got %b, want 0", w1.TREADY);
        end
        total++;
        if (st1 !== IDLE || st2 !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d/%0d, want IDLE", st1, st2);
        end
        total++;
        if (r2.TVALID !== 1'b0 || w2.TREADY !== 1'b0) begin
            bad++;
            $display("FAIL reset_msb: got rvalid=%b wready=%b, want 0 0", r2.TVALID, w2.TREADY);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (w1.TREADY !== 1'b1 || r1.TVALID !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got wready=%b rvalid=%b, want 1 0", w1.TREADY, r1.TVALID);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [4];
        logic       exp_l;
        exp_d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        @(posedge clk); #1;
        w1.TVALID = 1'b1; w1.TDATA = 32'hAABBCCDD; w1.TLAST = 1'b1; r1.TREADY = 1'b1;
        @(negedge clk);
        total++;
        if (w1.TREADY !== 1'b1) begin
            bad++;
            $display("FAIL single_load: wready got %b, want 1", w1.TREADY);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            w1.TVALID = 1'b0;
            @(negedge clk);
            exp_l = (k == 3);
            total++;
            if (r1.TVALID !== 1'b1 || r1.TDATA !== exp_d[k] || r1.TLAST !== exp_l) begin
                bad++;
                $display("FAIL single_slice%0d: got v=%b d=%h l=%b, want 1 %h %b",
                         k, r1.TVALID, r1.TDATA, r1.TLAST, exp_d[k], exp_l);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: rvalid got %b, want 0", r1.TVALID);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_d [4];
        logic       exp_l;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(posedge clk); #1;
        w2.TVALID = 1'b1; w2.TDATA = 32'h11223344; w2.TLAST = 1'b1; r2.TREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            w2.TVALID = 1'b0;
            @(negedge clk);
            exp_l = (k == 3);
            total++;
            if (r2.TVALID !== 1'b1 || r2.TDATA !== exp_d[k] || r2.TLAST !== exp_l) begin
                bad++;
                $display("FAIL msb_slice%0d: got v=%b d=%h l=%b, want 1 %h %b",
                         k, r2.TVALID, r2.TDATA, r2.TLAST, exp_d[k], exp_l);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic exp_wr;
        @(posedge clk); #1;
        w1.TVALID = 1'b1; w1.TDATA = 32'h03020100; w1.TLAST = 1'b0; r1.TREADY = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) w1.TDATA = 32'h07060504;
            if (c == 5) w1.TVALID = 1'b0;
            @(negedge clk);
            exp_wr = (c == 4) || (c == 8);
            total++;
            if (r1.TVALID !== 1'b1 || r1.TDATA !== 8'(c - 1) || w1.TREADY !== exp_wr) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got v=%b d=%h wready=%b, want 1 %h %b",
                         c, r1.TVALID, r1.TDATA, w1.TREADY, 8'(c - 1), exp_wr);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: rvalid got %b, want 0", r1.TVALID);
        end
    endtask

    task automatic test_backpressure();
        logic       rdy   [7];
        logic [7:0] exp_d [7];
        rdy   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_d = '{8'hDD, 8'hCC, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hAA};
        @(posedge clk); #1;
        w1.TVALID = 1'b1; w1.TDATA = 32'hAABBCCDD; w1.TLAST = 1'b1; r1.TREADY = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            w1.TVALID = 1'b0;
            r1.TREADY = rdy[c];
            @(negedge clk);
            total++;
            if (r1.TVALID !== 1'b1 || r1.TDATA !== exp_d[c] || (rdy[c] == 1'b0 && w1.TREADY !== 1'b0)) begin
                bad++;
                $display("FAIL bp_cycle%0d: got v=%b d=%h wready=%b, want 1 %h",
                         c, r1.TVALID, r1.TDATA, w1.TREADY, exp_d[c]);
            end
        end
        @(posedge clk); #1;
        r1.TREADY = 1'b1;
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle: rvalid got %b, want 0", r1.TVALID);
        end
    endtask

    task automatic test_reset_mid_beat();
        @(posedge clk); #1;
        w1.TVALID = 1'b1; w1.TDATA = 32'hAABBCCDD; w1.TLAST = 1'b1; r1.TREADY = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            w1.TVALID = 1'b0;
        end
        @(negedge clk);
        total++;
        if (r1.TDATA !== 8'hCC) begin
            bad++;
            $display("FAIL rst_mid_slice1: got %h, want cc", r1.TDATA);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; r1.TREADY = 1'b0;
        @(negedge clk);
        total++;
        if (w1.TREADY !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_wready: got %b, want 0", w1.TREADY);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b0 || st1 !== IDLE) begin
            bad++;
            $display("FAIL rst_mid_flush: got rvalid=%b state=%0d, want 0 IDLE", r1.TVALID, st1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; r1.TREADY = 1'b1;
        w1.TVALID = 1'b1; w1.TDATA = 32'h44332211; w1.TLAST = 1'b1;
        @(posedge clk); #1;
        w1.TVALID = 1'b0;
        @(negedge clk);
        total++;
        if (r1.TVALID !== 1'b1 || r1.TDATA !== 8'h11) begin
            bad++;
            $display("FAIL rst_mid_fresh: got v=%b d=%h, want 1 11", r1.TVALID, r1.TDATA);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_stress();
        int n_beats = 1200;
        int sent = 0;
        int cyc  = 0;
        int wait_cyc = 0;
        in_last_cnt  = 0;
        out_last_cnt = 0;
        w1.TVALID = 1'b0;
        while (sent < n_beats && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (w1.TVALID && w1_fire) begin
                w1.TVALID = 1'b0;
                sent++;
            end
            if (!w1.TVALID && sent < n_beats && $urandom_range(0, 1) == 1) begin
                w1.TVALID = 1'b1;
                w1.TDATA  = $urandom;
                w1.TLAST  = ($urandom_range(0, 3) == 0);
            end
            r1.TREADY = ($urandom_range(0, 1) == 1);
        end
        total++;
        if (sent != n_beats) begin
            bad++;
            $display("FAIL stress_timeout: sent %0d beats, want %0d", sent, n_beats);
        end
        w1.TVALID = 1'b0;
        r1.TREADY = 1'b1;
        while ((exp_q.size() != 0 || r1.TVALID) && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL stress_drain: %0d slices still expected, want 0", exp_q.size());
        end
        total++;
        if (out_last_cnt != in_last_cnt || in_last_cnt == 0) begin
            bad++;
            $display("FAIL stress_tlast: got %0d output TLASTs, want %0d", out_last_cnt, in_last_cnt);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        w1.TVALID = 1'b0; w1.TDATA = '0; w1.TLAST = 1'b0; r1.TREADY = 1'b1;
        w2.TVALID = 1'b0; w2.TDATA = '0; w2.TLAST = 1'b0; r2.TREADY = 1'b1;
        test_reset();
        test_single();
        test_msb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_beat();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
